ir_cursor_mover: RTL and testbench

- Consumes the decoded direction strobes from the IR command parser.
- Turns each valid command into a smooth, frame-synchronous glide of a cursor/sprite position on the 640x480 VGA raster, clamped to the visible area.
- Outputs PosX/PosY feed the sprite renderer. Updates occur only on FrameStart so nothing moves mid-frame.

---
 rtl/ir_cursor_mover.sv | 185 ++++++++++++++++++
 tb/tb_ir_cursor_mover.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ir_cursor_mover.sv
// Frame-synchronous cursor glide driven by IR direction commands.
// Each accepted command moves the sprite STEP pixels per frame for GLIDE_FRAMES frames, clamped to the visible area.
module ir_cursor_mover #(
    parameter int unsigned H_MAX        = 640,
    parameter int unsigned V_MAX        = 480,
    parameter int unsigned SPRITE_W     = 16,
    parameter int unsigned SPRITE_H     = 16,
    parameter int unsigned STEP         = 4,
    parameter int unsigned GLIDE_FRAMES = 8,
    parameter int unsigned X_INIT       = 312,
    parameter int unsigned Y_INIT       = 232
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Up,
    input  logic       Down,
    input  logic       Left,
    input  logic       Right,
    input  logic       Readable,
    input  logic       FrameStart,
    output logic [9:0] PosX,
    output logic [9:0] PosY,
    output logic       Moving,
    output logic       Bump
);

    localparam logic [10:0] STEP_W    = 11'(STEP);
    localparam logic [10:0] X_LIM     = 11'(H_MAX - SPRITE_W);
    localparam logic [10:0] Y_LIM     = 11'(V_MAX - SPRITE_H);
    localparam logic [7:0]  CNT_INIT  = 8'(GLIDE_FRAMES);
    localparam logic [9:0]  X_RESET   = 10'(X_INIT);
    localparam logic [9:0]  Y_RESET   = 10'(Y_INIT);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GLIDE = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    state_t      state_r;
    dir_t        dir_r;
    logic [7:0]  glide_cnt_r;
    logic [9:0]  pos_x_r;
    logic [9:0]  pos_y_r;
    logic        moving_r;
    logic        bump_r;
    logic        readable_prev_r;

    logic        cmd_edge_s;
    logic        cmd_onehot_s;
    logic        cmd_valid_s;
    dir_t        cmd_dir_s;
    logic [10:0] x_ext_s;
    logic [10:0] y_ext_s;
    logic [9:0]  step_x_s;
    logic [9:0]  step_y_s;
    logic        step_clamp_s;

    assign cmd_edge_s = Readable & ~readable_prev_r;
    assign x_ext_s    = {1'b0, pos_x_r};
    assign y_ext_s    = {1'b0, pos_y_r};

    // Decode the direction levels; only a single asserted direction forms a command.
    always_comb begin
        cmd_dir_s    = DIR_RIGHT;
        cmd_onehot_s = 1'b0;
        case ({Up, Down, Left, Right})
            4'b1000: begin cmd_dir_s = DIR_UP;    cmd_onehot_s = 1'b1; end
            4'b0100: begin cmd_dir_s = DIR_DOWN;  cmd_onehot_s = 1'b1; end
            4'b0010: begin cmd_dir_s = DIR_LEFT;  cmd_onehot_s = 1'b1; end
            4'b0001: begin cmd_dir_s = DIR_RIGHT; cmd_onehot_s = 1'b1; end
            default: begin cmd_dir_s = DIR_RIGHT; cmd_onehot_s = 1'b0; end
        endcase
        cmd_valid_s = cmd_edge_s & cmd_onehot_s;
    end

    // Candidate position one step along the current direction, saturated at the raster edges.
    always_comb begin
        step_x_s     = pos_x_r;
        step_y_s     = pos_y_r;
        step_clamp_s = 1'b0;
        case (dir_r)
            DIR_LEFT: begin
                if (x_ext_s >= STEP_W) begin
                    step_x_s = 10'(x_ext_s - STEP_W);
                end else begin
                    step_x_s     = 10'd0;
                    step_clamp_s = 1'b1;
                end
            end
            DIR_RIGHT: begin
                if (x_ext_s + STEP_W <= X_LIM) begin
                    step_x_s = 10'(x_ext_s + STEP_W);
                end else begin
                    step_x_s     = X_LIM[9:0];
                    step_clamp_s = 1'b1;
                end
            end
            DIR_UP: begin
                if (y_ext_s >= STEP_W) begin
                    step_y_s = 10'(y_ext_s - STEP_W);
                end else begin
                    step_y_s     = 10'd0;
                    step_clamp_s = 1'b1;
                end
            end
            DIR_DOWN: begin
                if (y_ext_s + STEP_W <= Y_LIM) begin
                    step_y_s = 10'(y_ext_s + STEP_W);
                end else begin
                    step_y_s     = Y_LIM[9:0];
                    step_clamp_s = 1'b1;
                end
            end
            default: begin
                step_x_s     = pos_x_r;
                step_y_s     = pos_y_r;
                step_clamp_s = 1'b0;
            end
        endcase
    end

    // Glide FSM: a new command reloads the frame count even when it lands on a FrameStart.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r         <= ST_IDLE;
            dir_r           <= DIR_RIGHT;
            glide_cnt_r     <= 8'd0;
            pos_x_r         <= X_RESET;
            pos_y_r         <= Y_RESET;
            moving_r        <= 1'b0;
            bump_r          <= 1'b0;
            readable_prev_r <= 1'b1;
        end else begin
            readable_prev_r <= Readable;
            bump_r          <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid_s) begin
                        dir_r       <= cmd_dir_s;
                        glide_cnt_r <= CNT_INIT;
                        state_r     <= ST_GLIDE;
                        moving_r    <= 1'b1;
                    end
                end
                ST_GLIDE: begin
                    if (FrameStart) begin
                        pos_x_r <= step_x_s;
                        pos_y_r <= step_y_s;
                        bump_r  <= step_clamp_s;
                    end
                    if (cmd_valid_s) begin
                        dir_r       <= cmd_dir_s;
                        glide_cnt_r <= CNT_INIT;
                    end else if (FrameStart) begin
                        if (glide_cnt_r <= 8'd1) begin
                            glide_cnt_r <= 8'd0;
                            state_r     <= ST_IDLE;
                            moving_r    <= 1'b0;
                        end else begin
                            glide_cnt_r <= glide_cnt_r - 8'd1;
                        end
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    glide_cnt_r <= 8'd0;
                    moving_r    <= 1'b0;
                end
            endcase
        end
    end

    assign PosX   = pos_x_r;
    assign PosY   = pos_y_r;
    assign Moving = moving_r;
    assign Bump   = bump_r;

endmodule

// File: tb/tb_ir_cursor_mover.sv
// Scoreboard bench for ir_cursor_mover: a frame-level reference model predicts every post-FrameStart output.
module tb_ir_cursor_mover;

    localparam int X_MAXPOS = 640 - 16;
    localparam int Y_MAXPOS = 480 - 16;
    localparam int STEP     = 4;
    localparam int FRAMES   = 8;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       Up, Down, Left, Right;
    logic       Readable;
    logic       FrameStart;
    logic [9:0] PosX, PosY;
    logic       Moving, Bump;

    typedef struct {
        int x;
        int y;
        bit mv;
        bit bp;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: position, frames left in the glide and unit direction vector.
    int m_x, m_y, m_rem, m_dx, m_dy;
    bit m_prev, m_bump;

    ir_cursor_mover dut (
        .Clock(Clock), .Reset(Reset),
        .Up(Up), .Down(Down), .Left(Left), .Right(Right),
        .Readable(Readable), .FrameStart(FrameStart),
        .PosX(PosX), .PosY(PosY), .Moving(Moving), .Bump(Bump)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge with the inputs about to be sampled.
    task automatic model_edge(input logic [3:0] udlr, input bit rd, input bit fs, input bit rst);
        int  nx, ny;
        bit  cmd_edge;
        exp_t e;
        if (rst) begin
            m_x = 312; m_y = 232; m_rem = 0; m_dx = 1; m_dy = 0;
            m_prev = 1'b1; m_bump = 1'b0;
        end else begin
            cmd_edge = rd && !m_prev;
            m_prev   = rd;
            m_bump   = 1'b0;
            if (fs && m_rem > 0) begin
                nx = m_x + m_dx * STEP;
                ny = m_y + m_dy * STEP;
                if (nx < 0) begin nx = 0; m_bump = 1'b1; end
                if (nx > X_MAXPOS) begin nx = X_MAXPOS; m_bump = 1'b1; end
                if (ny < 0) begin ny = 0; m_bump = 1'b1; end
                if (ny > Y_MAXPOS) begin ny = Y_MAXPOS; m_bump = 1'b1; end
                m_x = nx; m_y = ny;
                m_rem--;
            end
            if (cmd_edge && $countones(udlr) == 1) begin
                m_dx  = udlr[0] ? 1 : (udlr[1] ? -1 : 0);
                m_dy  = udlr[2] ? 1 : (udlr[3] ? -1 : 0);
                m_rem = FRAMES;
            end
            if (fs) begin
                e.x = m_x; e.y = m_y; e.mv = (m_rem > 0); e.bp = m_bump;
                exp_q.push_back(e);
            end
        end
    endtask

    // udlr = {Up, Down, Left, Right}
    task automatic drive(input logic [3:0] udlr, input bit rd, input bit fs, input bit rst);
        {Up, Down, Left, Right} = udlr;
        Readable   = rd;
        FrameStart = fs;
        Reset      = rst;
        model_edge(udlr, rd, fs, rst);
        @(posedge Clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(4'b0000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic cmd(input logic [3:0] udlr);
        drive(udlr, 1'b1, 1'b0, 1'b0);
        drive(4'b0000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            drive(4'b0000, 1'b0, 1'b1, 1'b0);
            idle(2);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_x"}, int'(PosX), m_x);
        check({tag, "_y"}, int'(PosY), m_y);
        check({tag, "_moving"}, int'(Moving), int'(m_rem > 0));
        check({tag, "_bump"}, int'(Bump), int'(m_bump));
    endtask

    // Monitor: every FrameStart taken outside reset yields one scoreboard entry the following cycle.
    initial begin
        bit   fs_seen;
        exp_t e;
        forever begin
            @(posedge Clock);
            fs_seen = (FrameStart === 1'b1) && (Reset === 1'b0);
            @(negedge Clock);
            if (fs_seen) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_posx", int'(PosX), e.x);
                    check("sb_posy", int'(PosY), e.y);
                    check("sb_moving", int'(Moving), int'(e.mv));
                    check("sb_bump", int'(Bump), int'(e.bp));
                end
            end
        end
    end

    initial begin
        logic [3:0] r_udlr;
        bit         r_rd, r_fs, r_rst;

        // Reset with Readable already high through release.
        drive(4'b0000, 1'b1, 1'b0, 1'b1);
        drive(4'b0000, 1'b1, 1'b0, 1'b1);
        check_state("reset");
        drive(4'b0001, 1'b1, 1'b0, 1'b0);
        drive(4'b0001, 1'b1, 1'b1, 1'b0);
        idle(2);
        check_state("rd_held_at_release");

        // Right glide: 8 steps then idle.
        cmd(4'b0001);
        check_state("right_start");
        frames(10);
        check_state("right_done");

        // Left glides into the left edge to exercise clamping and Bump.
        for (int i = 0; i < 11; i++) begin
            cmd(4'b0010);
            frames(8);
        end
        check_state("left_pinned");

        // Two directions at once is discarded.
        drive(4'b0000, 1'b0, 1'b0, 1'b1);
        drive(4'b0000, 1'b0, 1'b0, 1'b0);
        cmd(4'b1010);
        check_state("multi_dir_discard");
        frames(2);

        // Readable held for 100 cycles gives a single glide.
        for (int i = 0; i < 100; i++) drive(4'b0100, 1'b1, (i % 10) == 5, 1'b0);
        idle(1);
        check_state("held_readable");

        // Retarget mid-glide, then retarget coincident with a FrameStart.
        drive(4'b0000, 1'b0, 1'b0, 1'b1);
        cmd(4'b0001);
        frames(5);
        cmd(4'b0100);
        frames(10);
        check_state("retarget");
        cmd(4'b0001);
        frames(3);
        drive(4'b0100, 1'b1, 1'b1, 1'b0);
        idle(2);
        frames(9);
        check_state("retarget_coincident");

        // Down glides to the bottom edge, then reset mid-glide.
        for (int i = 0; i < 9; i++) begin
            cmd(4'b0100);
            frames(8);
        end
        cmd(4'b0001);
        frames(3);
        drive(4'b0000, 1'b0, 1'b0, 1'b1);
        check_state("reset_mid_glide");
        drive(4'b0000, 1'b0, 1'b0, 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) r_udlr = 4'($urandom_range(0, 15));
            else                           r_udlr = 4'b0001 << $urandom_range(0, 3);
            r_rd  = ($urandom_range(0, 9) < 3);
            r_fs  = ($urandom_range(0, 5) == 0);
            r_rst = ($urandom_range(0, 499) == 0);
            drive(r_udlr, r_rd, r_fs, r_rst);
        end
        idle(3);
        check_state("random_end");
        check("sb_drain", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
